// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller for an in-order pipeline. It issues the data-memory
// access for the instruction in EX/MEM and stalls the front of the pipe until
// the memory acknowledges. It also selects and registers the writeback value.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   Predicate_mem        slot valid / predicate true
//   Res_mem, Data_mem    ALU result (effective address), store data
//   RW_mem, RegWrite_mem destination register and its write enable
//   MEMRd_mem/MEMWr_mem  load / store (both set => store)
//   WB_data_mem          writeback select: 00 Res, 01 load data, 10 PC+4, 11 Res
//   PCPLUS_mem           return address
//   dmem_*               request/acknowledge data-memory interface
//   mem_stall            freeze IF/ID/EX and EX/MEM while an access is pending
//   WB_value_wb, RW_wb, RegWrite_wb  MEM/WB register
//   mem_err              one-cycle pulse after an access times out
//
// Build option: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// wait cycles. Without it, a pending access waits forever and mem_err is 0.
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Predicate_mem,
    input  logic [31:0] Res_mem,
    input  logic [31:0] Data_mem,
    input  logic [4:0]  RW_mem,
    input  logic        MEMRd_mem,
    input  logic        MEMWr_mem,
    input  logic        RegWrite_mem,
    input  logic [1:0]  WB_data_mem,
    input  logic [31:0] PCPLUS_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic [31:0] WB_value_wb,
    output logic [4:0]  RW_wb,
    output logic        RegWrite_wb,
    output logic        mem_err
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pcplus;
    logic        r_we;
    logic [4:0]  r_rw;
    logic        r_regwrite;
    logic [1:0]  r_wbsel;

    logic        w_access;
    logic        w_wait;
    logic        w_abort;
    logic        w_slot_ok;
    logic [1:0]  w_sel;
    logic [31:0] w_res;
    logic [31:0] w_pc;
    logic [31:0] w_wbval;

    assign w_access = Predicate_mem & (MEMRd_mem | MEMWr_mem);
    assign w_wait   = (r_state == S_WAIT);

    // Memory interface: live inputs in IDLE, latched copies while waiting.
    // MEMWr_mem alone decides the strobe, so rd+wr together acts as a store.
    assign dmem_req   = ~reset & (w_wait | w_access);
    assign dmem_we    = ~reset & (w_wait ? r_we : (w_access & MEMWr_mem));
    assign dmem_addr  = w_wait ? r_addr  : Res_mem;
    assign dmem_wdata = w_wait ? r_wdata : Data_mem;

    // An aborting access releases the stall in its final cycle so the frozen
    // instruction leaves EX/MEM instead of being re-issued.
    assign mem_stall = ~reset & ~dmem_ready & (w_wait ? ~w_abort : w_access);

    // Writeback source: the held access when finishing from WAIT, otherwise
    // whatever sits in EX/MEM right now.
    assign w_sel     = w_wait ? r_wbsel  : WB_data_mem;
    assign w_res     = w_wait ? r_addr   : Res_mem;
    assign w_pc      = w_wait ? r_pcplus : PCPLUS_mem;
    assign w_slot_ok = w_wait ? ~w_abort : Predicate_mem;

    always_comb begin
        w_wbval = w_res;
        case (w_sel)
            2'b01:   w_wbval = dmem_rdata;
            2'b10:   w_wbval = w_pc;
            default: w_wbval = w_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_pcplus    <= '0;
            r_we        <= 1'b0;
            r_rw        <= '0;
            r_regwrite  <= 1'b0;
            r_wbsel     <= '0;
            WB_value_wb <= '0;
            RW_wb       <= '0;
            RegWrite_wb <= 1'b0;
        end else begin
            if (mem_stall || !w_slot_ok) begin
                WB_value_wb <= '0;
                RW_wb       <= '0;
                RegWrite_wb <= 1'b0;
            end else begin
                WB_value_wb <= w_wbval;
                RW_wb       <= w_wait ? r_rw       : RW_mem;
                RegWrite_wb <= w_wait ? r_regwrite : RegWrite_mem;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_access && !dmem_ready) begin
                        r_state    <= S_WAIT;
                        r_addr     <= Res_mem;
                        r_wdata    <= Data_mem;
                        r_pcplus   <= PCPLUS_mem;
                        r_we       <= MEMWr_mem;
                        r_rw       <= RW_mem;
                        r_regwrite <= RegWrite_mem;
                        r_wbsel    <= WB_data_mem;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || w_abort) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_tcnt;
    logic          r_err;

    // r_tcnt holds the number of wait cycles already spent; it sits at 0 in
    // IDLE, so every entry into WAIT starts from a cleared count.
    assign w_abort = w_wait & ~dmem_ready & (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
    assign mem_err = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err  <= w_abort;
            r_tcnt <= (w_wait && !dmem_ready && !w_abort) ? r_tcnt + 1'b1 : '0;
        end
    end
`else
    assign w_abort = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl. A transaction-level model (one held
// access record plus a wait count) predicts the memory interface every cycle
// and the MEM/WB register after every edge. Directed sequences pin the model
// with literal values, then a long randomized run follows.
// Works with or without MEM_TIMEOUT_EN (the DUT is built with a 4-cycle limit).
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, Predicate_mem, MEMRd_mem, MEMWr_mem, RegWrite_mem, dmem_ready;
    logic [31:0] Res_mem, Data_mem, PCPLUS_mem, dmem_rdata;
    logic [4:0]  RW_mem;
    logic [1:0]  WB_data_mem;
    logic        dmem_req, dmem_we, mem_stall, RegWrite_wb, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, WB_value_wb;
    logic [4:0]  RW_wb;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .Predicate_mem(Predicate_mem),
        .Res_mem(Res_mem), .Data_mem(Data_mem), .RW_mem(RW_mem),
        .MEMRd_mem(MEMRd_mem), .MEMWr_mem(MEMWr_mem), .RegWrite_mem(RegWrite_mem),
        .WB_data_mem(WB_data_mem), .PCPLUS_mem(PCPLUS_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_stall(mem_stall), .WB_value_wb(WB_value_wb), .RW_wb(RW_wb),
        .RegWrite_wb(RegWrite_wb), .mem_err(mem_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rw;
        logic        rwe;
        logic [1:0]  sel;
    } txn_t;

    // Model state: is an access outstanding, what it is, how long it has waited.
    bit          m_busy;
    txn_t        m_held;
    int          m_waits;
    logic [31:0] m_wbv;
    logic [4:0]  m_wbrw;
    logic        m_wbwe;
    logic        m_err;

    // Mid-cycle snapshot of the memory interface for directed checks.
    logic        c_req, c_we, c_stall;
    logic [31:0] c_addr, c_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wbval(input logic [1:0] sel, input logic [31:0] res,
                                          input logic [31:0] pc, input logic [31:0] rd);
        if (sel == 2'b01) return rd;
        if (sel == 2'b10) return pc;
        return res;
    endfunction

    task automatic bubble();
        m_wbv = 0; m_wbrw = 0; m_wbwe = 0;
    endtask

    // Inputs are already driven (1 ns after posedge). Check the interface
    // mid-cycle, advance the model, cross the edge, check the registers.
    task automatic step();
        logic acc, abort, e_req, e_we, e_stall;
        logic [31:0] e_addr, e_wdata;
        #3;
        c_req = dmem_req; c_we = dmem_we; c_stall = mem_stall;
        c_addr = dmem_addr; c_wdata = dmem_wdata;

        acc   = Predicate_mem && (MEMRd_mem || MEMWr_mem);
        abort = TMO_ON && m_busy && (m_waits == TMO - 1) && !dmem_ready;
        e_addr = Res_mem; e_wdata = Data_mem;
        if (reset) begin
            e_req = 0; e_we = 0; e_stall = 0;
        end else if (m_busy) begin
            e_req = 1; e_we = m_held.we; e_addr = m_held.addr; e_wdata = m_held.wdata;
            e_stall = !dmem_ready && !abort;
        end else begin
            e_req = acc; e_we = acc && MEMWr_mem; e_stall = acc && !dmem_ready;
        end
        chk("dmem_req", c_req, e_req);
        chk("dmem_we", c_we, e_we);
        chk("mem_stall", c_stall, e_stall);
        if (e_req) begin
            chk("dmem_addr", c_addr, e_addr);
            chk("dmem_wdata", c_wdata, e_wdata);
        end

        m_err = 0;
        if (reset) begin
            m_busy = 0; m_waits = 0; bubble();
        end else if (m_busy) begin
            if (dmem_ready) begin
                m_wbv  = wbval(m_held.sel, m_held.addr, m_held.pc, dmem_rdata);
                m_wbrw = m_held.rw; m_wbwe = m_held.rwe; m_busy = 0;
            end else if (abort) begin
                bubble(); m_busy = 0; m_err = 1;
            end else begin
                bubble(); m_waits++;
            end
        end else if (acc && !dmem_ready) begin
            m_held = '{addr: Res_mem, wdata: Data_mem, pc: PCPLUS_mem, we: MEMWr_mem,
                       rw: RW_mem, rwe: RegWrite_mem, sel: WB_data_mem};
            m_busy = 1; m_waits = 0; bubble();
        end else if (!Predicate_mem) begin
            bubble();
        end else begin
            m_wbv  = wbval(WB_data_mem, Res_mem, PCPLUS_mem, dmem_rdata);
            m_wbrw = RW_mem; m_wbwe = RegWrite_mem;
        end

        @(posedge clk);
        #1;
        chk("WB_value_wb", WB_value_wb, m_wbv);
        chk("RW_wb", RW_wb, m_wbrw);
        chk("RegWrite_wb", RegWrite_wb, m_wbwe);
        chk("mem_err", mem_err, m_err);
    endtask

    task automatic nop();
        reset = 0; Predicate_mem = 1; MEMRd_mem = 0; MEMWr_mem = 0; RegWrite_mem = 0;
        Res_mem = 0; Data_mem = 0; RW_mem = 0; WB_data_mem = 0; PCPLUS_mem = 0;
        dmem_ready = 0; dmem_rdata = 0;
    endtask

    initial begin
        m_busy = 0; m_waits = 0; m_err = 0; m_held = '0; bubble();

        // Reset state
        nop(); reset = 1;
        step(); step();
        chk("rst_req", c_req, 0);
        chk("rst_stall", c_stall, 0);
        chk("rst_regwrite", RegWrite_wb, 0);
        chk("rst_wbval", WB_value_wb, 0);

        // Zero-wait load
        nop(); MEMRd_mem = 1; Res_mem = 32'h100; WB_data_mem = 2'b01; RW_mem = 5;
        RegWrite_mem = 1; dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
        step();
        chk("ld_stall", c_stall, 0);
        chk("ld_addr", c_addr, 32'h100);
        chk("ld_rw", RW_wb, 5);
        chk("ld_regwrite", RegWrite_wb, 1);
        chk("ld_value", WB_value_wb, 32'hDEADBEEF);

        // Store with three wait cycles; inputs scrambled while it waits
        nop(); MEMWr_mem = 1; MEMRd_mem = 1; Res_mem = 32'h40; Data_mem = 32'h1234;
        RW_mem = 7; RegWrite_mem = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                Res_mem = $urandom; Data_mem = $urandom; PCPLUS_mem = $urandom;
                MEMWr_mem = 0; RegWrite_mem = 0; RW_mem = 5'($urandom);
                WB_data_mem = 2'b10;
            end
            if (i == 3) dmem_ready = 1;
            step();
            chk("st_addr", c_addr, 32'h40);
            chk("st_wdata", c_wdata, 32'h1234);
            chk("st_we", c_we, 1);
            chk("st_stall", c_stall, (i < 3) ? 1 : 0);
            chk("st_regwrite", RegWrite_wb, (i < 3) ? 0 : 1);
        end
        chk("st_wb_rw", RW_wb, 7);
        chk("st_wb_value", WB_value_wb, 32'h40);

        // Predicated-off load
        nop(); Predicate_mem = 0; MEMRd_mem = 1; RegWrite_mem = 1; RW_mem = 3;
        step();
        chk("pf_req", c_req, 0);
        chk("pf_stall", c_stall, 0);
        chk("pf_regwrite", RegWrite_wb, 0);

        // ALU op returning PC+4
        nop(); WB_data_mem = 2'b10; PCPLUS_mem = 32'h2004; RW_mem = 31; RegWrite_mem = 1;
        Res_mem = 32'h55;
        step();
        chk("pc_value", WB_value_wb, 32'h2004);
        chk("pc_rw", RW_wb, 31);

        // Stray ready with nothing outstanding
        nop(); dmem_ready = 1; dmem_rdata = 32'hFFFF0000;
        step();
        chk("stray_req", c_req, 0);
        chk("stray_stall", c_stall, 0);

        // Reset on the second wait cycle
        nop(); MEMRd_mem = 1; RegWrite_mem = 1; RW_mem = 9; Res_mem = 32'h80;
        step(); step();
        reset = 1;
        step();
        chk("rw_req", c_req, 0);
        chk("rw_stall", c_stall, 0);
        chk("rw_regwrite", RegWrite_wb, 0);
        nop();
        step();
        chk("rw_after_req", c_req, 0);
        chk("rw_after_regwrite", RegWrite_wb, 0);

`ifdef MEM_TIMEOUT_EN
        // Timeout: ready never comes
        nop(); MEMRd_mem = 1; RegWrite_mem = 1; RW_mem = 4; Res_mem = 32'hC0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_stall", c_stall, 1);
            chk("to_err_early", mem_err, 0);
        end
        step();
        chk("to_stall_drop", c_stall, 0);
        chk("to_err", mem_err, 1);
        chk("to_regwrite", RegWrite_wb, 0);
        nop();
        step();
        chk("to_err_pulse", mem_err, 0);
        chk("to_after_stall", c_stall, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            Predicate_mem = ($urandom_range(0, 3) != 0);
            MEMRd_mem     = 1'($urandom);
            MEMWr_mem     = 1'($urandom);
            RegWrite_mem  = 1'($urandom);
            Res_mem       = $urandom;
            Data_mem      = $urandom;
            PCPLUS_mem    = $urandom;
            RW_mem        = 5'($urandom);
            WB_data_mem   = 2'($urandom);
            dmem_ready    = ($urandom_range(0, 2) == 0);
            dmem_rdata    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum WAIT cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- Predicate_mem  in  1  instruction valid/predicate-true.
- Res_mem  in  32  ALU result / effective address.
- Data_mem  in  32  store data.
- RW_mem  in  5  destination register.
- MEMRd_mem  in  1  load.
- MEMWr_mem  in  1  store.
- RegWrite_mem  in  1  register write enable.
- WB_data_mem  in  2  writeback select.
- PCPLUS_mem  in  32  return address.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  memory address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid with dmem_ready.
- dmem_ready  in  1  access complete.
- mem_stall  out  1  freeze IF/ID/EX and EX/MEM register.
- WB_value_wb  out  32  registered writeback value.
- RW_wb  out  5  registered destination.
- RegWrite_wb  out  1  registered write enable.
- mem_err  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL treat an instruction as a memory access when Predicate_mem=1 and (MEMRd_mem or MEMWr_mem)=1; Predicate_mem=0 SHALL suppress the access and force RegWrite_wb=0 for that slot.
REQ-004 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-005 In IDLE with an access present: dmem_req=1 combinationally, dmem_addr=Res_mem, dmem_wdata=Data_mem, dmem_we=MEMWr_mem.
REQ-006 In IDLE, dmem_ready=1 in the same cycle SHALL complete the access with zero wait states; else FSM SHALL move to WAIT and latch addr, wdata, we, RW, RegWrite, WB select.
REQ-007 In WAIT: dmem_req=1 and dmem_addr/wdata/we SHALL be driven from the latched copies regardless of input changes; dmem_ready=1 completes the access and returns to IDLE.
REQ-008 mem_stall SHALL equal (access present in IDLE and dmem_ready=0) or (state WAIT and dmem_ready=0).
REQ-009 When MEMRd_mem and MEMWr_mem are both 1, the access SHALL be a store (dmem_we=1).
REQ-010 Writeback mux: 00 Res, 01 dmem_rdata captured at completion, 10 PCPLUS, 11 Res.
REQ-011 WB register SHALL load on every clock: the completing or non-memory instruction's values when mem_stall=0, a bubble (RegWrite_wb=0, RW_wb=0, WB_value_wb=0) when mem_stall=1; latency one cycle.
REQ-012 A store SHALL set RegWrite_wb to the latched RegWrite value unchanged (no implicit suppression).
REQ-013 dmem_ready while no request is outstanding SHALL be ignored.

Reset
REQ-014 reset SHALL force state IDLE, RegWrite_wb=0, RW_wb=0, WB_value_wb=0, mem_err=0, timeout counter=0, latched fields=0.
REQ-015 During a reset cycle dmem_req, dmem_we and mem_stall SHALL be 0; reset in WAIT SHALL abandon the access with no writeback.

Configuration
REQ-016 Macro MEM_TIMEOUT_EN: when defined, a counter SHALL count WAIT cycles; when the count reaches TIMEOUT_CYCLES-1 with dmem_ready=0, the access SHALL abort, FSM SHALL return to IDLE, mem_err SHALL pulse for 1 cycle, mem_stall SHALL drop, and the slot SHALL write back as a bubble; counter clears on entering WAIT.
REQ-017 Without MEM_TIMEOUT_EN, WAIT SHALL persist until dmem_ready and mem_err SHALL be tied 0.

Verification
REQ-018 Load, Res=0x100, WB=01, RW=5, dmem_ready=1 same cycle, rdata=0xDEADBEEF -> mem_stall=0, next cycle RW_wb=5, RegWrite_wb=1, WB_value_wb=0xDEADBEEF.
REQ-019 Store, addr 0x40, data 0x1234, ready after 3 cycles, inputs changed after first cycle -> dmem_addr=0x40, wdata=0x1234, we=1 held 4 cycles, mem_stall=1 for 3 cycles, bubbles written back.
REQ-020 Load with Predicate_mem=0 -> dmem_req=0, mem_stall=0, RegWrite_wb=0.
REQ-021 ALU op WB=10, PCPLUS=0x2004, RW=31 -> next cycle WB_value_wb=0x2004, RW_wb=31.
REQ-022 Reset asserted on 2nd WAIT cycle -> next cycle IDLE, dmem_req=0, RegWrite_wb=0.
REQ-023 MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, dmem_ready held 0 -> mem_err=1 for exactly 1 cycle after 4th WAIT cycle, mem_stall=0 thereafter, RegWrite_wb=0.
